// File: rtl/data_mem.sv
// Byte-addressed data memory: word/half/byte loads with sign/zero extension,
// lane-merged stores, synchronous clear and a per-store simulation trace.
module data_mem #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic        memwrite,
    input  logic [1:0]  memop,
    input  logic        load_signed,
    input  logic [31:0] pc,
    output logic [31:0] rd,
    output logic        addr_err
);

    localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned BYTE_SPAN  = 4 * DEPTH_WORDS;

    localparam logic [1:0] OP_WORD = 2'b00;
    localparam logic [1:0] OP_HALF = 2'b01;
    localparam logic [1:0] OP_BYTE = 2'b10;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [IDX_W-1:0] idx;
    logic [31:0]      cur;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;
    logic [31:0]      load_val;
    logic [3:0]       be;
    logic [31:0]      wlanes;
    logic [31:0]      merged;
    logic             commit;

    assign idx = addr[IDX_W+1:2];
    assign cur = mem[idx];

    // Legality: range, natural alignment, reserved size code.
    always_comb begin
        addr_err = 1'b0;
        if (addr >= 32'(BYTE_SPAN))                 addr_err = 1'b1;
        if (memop == OP_WORD && addr[1:0] != 2'b00) addr_err = 1'b1;
        if (memop == OP_HALF && addr[0])            addr_err = 1'b1;
        if (memop == 2'b11)                         addr_err = 1'b1;
    end

    // Load path: lane select, extend, and force zero on an illegal access.
    always_comb begin
        half_sel = addr[1] ? cur[31:16] : cur[15:0];
        byte_sel = cur[7:0];
        case (addr[1:0])
            2'b00:   byte_sel = cur[7:0];
            2'b01:   byte_sel = cur[15:8];
            2'b10:   byte_sel = cur[23:16];
            default: byte_sel = cur[31:24];
        endcase
        load_val = 32'h0;
        case (memop)
            OP_WORD: load_val = cur;
            OP_HALF: load_val = load_signed ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            OP_BYTE: load_val = load_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            default: load_val = 32'h0;
        endcase
        rd = addr_err ? 32'h0 : load_val;
    end

    // Store path: replicate the store data into every lane, then merge by byte enable.
    always_comb begin
        be     = 4'b0000;
        wlanes = wd;
        case (memop)
            OP_WORD: begin
                be     = 4'b1111;
                wlanes = wd;
            end
            OP_HALF: begin
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wd[15:0]}};
            end
            OP_BYTE: begin
                be     = 4'b0001 << addr[1:0];
                wlanes = {4{wd[7:0]}};
            end
            default: be = 4'b0000;
        endcase
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? wlanes[8*b +: 8] : cur[8*b +: 8];
        end
    end

    assign commit = memwrite && !addr_err;

    // Array update; the simulation trace fires only for a committed store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (commit) begin
            mem[idx] <= merged;
            $write("@%h: *%h <= %h\n", pc, {addr[31:2], 2'b00}, merged);
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Directed bench for data_mem: loads, lane stores, illegal accesses,
// reset interaction and back-to-back stores against hand-computed values.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        memwrite;
    logic [1:0]  memop;
    logic        load_signed;
    logic [31:0] pc;
    logic [31:0] rd;
    logic        addr_err;

    int n_cmp = 0;
    int n_err = 0;

    data_mem #(.DEPTH_WORDS(1024)) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .wd          (wd),
        .memwrite    (memwrite),
        .memop       (memop),
        .load_signed (load_signed),
        .pc          (pc),
        .rd          (rd),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    // Apply one access at the falling edge and let combinational outputs settle.
    task automatic drive(input logic [31:0] a, input logic [1:0] op, input logic sgn,
                         input logic we, input logic [31:0] d, input logic [31:0] p);
        @(negedge clk);
        addr        = a;
        memop       = op;
        load_signed = sgn;
        memwrite    = we;
        wd          = d;
        pc          = p;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(32'h0, 2'b11, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (addr_err !== 1'b1) begin
            n_err++; $display("FAIL reset_err_comb got=%b exp=1", addr_err);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h10, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h0 || addr_err !== 1'b0) begin
            n_err++; $display("FAIL reset_rd_10 got=%h/%b exp=00000000/0", rd, addr_err);
        end
        drive(32'hFFC, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h0 || addr_err !== 1'b0) begin
            n_err++; $display("FAIL reset_rd_ffc got=%h/%b exp=00000000/0", rd, addr_err);
        end
    endtask

    task automatic test_word_store();
        drive(32'h10, 2'b00, 1'b0, 1'b1, 32'h12345678, 32'h3000);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL word_pre_edge got=%h exp=00000000", rd);
        end
        @(posedge clk); #1;
        memwrite = 1'b0;
        #1;
        n_cmp++;
        if (rd !== 32'h12345678) begin
            n_err++; $display("FAIL word_load got=%h exp=12345678", rd);
        end
    endtask

    task automatic test_byte_store();
        drive(32'h13, 2'b10, 1'b0, 1'b1, 32'h000000AB, 32'h3004);
        @(posedge clk); #1;
        memwrite = 1'b0;
        drive(32'h10, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'hAB345678) begin
            n_err++; $display("FAIL byte_merge got=%h exp=ab345678", rd);
        end
        drive(32'h13, 2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'hFFFFFFAB) begin
            n_err++; $display("FAIL byte_signed got=%h exp=ffffffab", rd);
        end
        drive(32'h13, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h000000AB) begin
            n_err++; $display("FAIL byte_unsigned got=%h exp=000000ab", rd);
        end
        drive(32'h10, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h00000078) begin
            n_err++; $display("FAIL byte_lane0 got=%h exp=00000078", rd);
        end
        drive(32'h11, 2'b10, 1'b1, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h00000056) begin
            n_err++; $display("FAIL byte_lane1 got=%h exp=00000056", rd);
        end
        drive(32'h12, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h0000AB34) begin
            n_err++; $display("FAIL half_upper_10 got=%h exp=0000ab34", rd);
        end
    endtask

    task automatic test_half_store();
        drive(32'h22, 2'b01, 1'b0, 1'b1, 32'h00008001, 32'h3008);
        @(posedge clk); #1;
        memwrite = 1'b0;
        drive(32'h20, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h80010000) begin
            n_err++; $display("FAIL half_merge got=%h exp=80010000", rd);
        end
        drive(32'h22, 2'b01, 1'b1, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'hFFFF8001) begin
            n_err++; $display("FAIL half_signed got=%h exp=ffff8001", rd);
        end
        drive(32'h22, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h00008001) begin
            n_err++; $display("FAIL half_unsigned got=%h exp=00008001", rd);
        end
        drive(32'h20, 2'b01, 1'b1, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h00000000) begin
            n_err++; $display("FAIL half_lower got=%h exp=00000000", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] ea [4];
        logic [1:0]  eo [4];
        ea[0] = 32'h11;   eo[0] = 2'b00;
        ea[1] = 32'h21;   eo[1] = 2'b01;
        ea[2] = 32'h1000; eo[2] = 2'b00;
        ea[3] = 32'h10;   eo[3] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            drive(ea[k], eo[k], 1'b1, 1'b1, 32'hDEADBEEF, 32'h4000);
            n_cmp++;
            if (addr_err !== 1'b1 || rd !== 32'h0) begin
                n_err++; $display("FAIL err_case%0d got=%b/%h exp=1/00000000", k, addr_err, rd);
            end
            @(posedge clk); #1;
            memwrite = 1'b0;
        end
        drive(32'h10, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'hAB345678) begin
            n_err++; $display("FAIL err_keep_10 got=%h exp=ab345678", rd);
        end
        drive(32'h20, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h80010000) begin
            n_err++; $display("FAIL err_keep_20 got=%h exp=80010000", rd);
        end
        drive(32'h0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL err_keep_00 got=%h exp=00000000", rd);
        end
        drive(32'h23, 2'b01, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (addr_err !== 1'b1) begin
            n_err++; $display("FAIL err_half_23 got=%b exp=1", addr_err);
        end
        drive(32'hFFF, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (addr_err !== 1'b0) begin
            n_err++; $display("FAIL err_byte_fff got=%b exp=0", addr_err);
        end
        drive(32'h1000, 2'b10, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (addr_err !== 1'b1) begin
            n_err++; $display("FAIL err_byte_1000 got=%b exp=1", addr_err);
        end
        // memwrite low must never change the array.
        drive(32'h10, 2'b00, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h4010);
        @(posedge clk); #1;
        n_cmp++;
        if (rd !== 32'hAB345678) begin
            n_err++; $display("FAIL nowrite_keep got=%h exp=ab345678", rd);
        end
    endtask

    task automatic test_reset_store();
        drive(32'h44, 2'b00, 1'b0, 1'b1, 32'hCAFEF00D, 32'h5000);
        @(posedge clk); #1;
        drive(32'h40, 2'b00, 1'b0, 1'b1, 32'h55AA55AA, 32'h5004);
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        memwrite = 1'b0;
        #1;
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL rst_store_40 got=%h exp=00000000", rd);
        end
        drive(32'h44, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL rst_discard_44 got=%h exp=00000000", rd);
        end
        drive(32'h10, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++; $display("FAIL rst_clear_10 got=%h exp=00000000", rd);
        end
        drive(32'h48, 2'b00, 1'b0, 1'b1, 32'h0BADCAFE, 32'h5008);
        @(posedge clk); #1;
        memwrite = 1'b0;
        #1;
        n_cmp++;
        if (rd !== 32'h0BADCAFE) begin
            n_err++; $display("FAIL post_rst_store got=%h exp=0badcafe", rd);
        end
    endtask

    task automatic test_back_to_back();
        drive(32'h8, 2'b00, 1'b0, 1'b1, 32'h11111111, 32'h6000);
        @(posedge clk); #1;
        drive(32'h8, 2'b00, 1'b0, 1'b1, 32'h22222222, 32'h6004);
        n_cmp++;
        if (rd !== 32'h11111111) begin
            n_err++; $display("FAIL b2b_before got=%h exp=11111111", rd);
        end
        @(posedge clk); #1;
        memwrite = 1'b0;
        #1;
        n_cmp++;
        if (rd !== 32'h22222222) begin
            n_err++; $display("FAIL b2b_after got=%h exp=22222222", rd);
        end
    endtask

    initial begin
        reset       = 1'b1;
        addr        = 32'h0;
        wd          = 32'h0;
        memwrite    = 1'b0;
        memop       = 2'b00;
        load_signed = 1'b0;
        pc          = 32'h0;
        test_reset();
        test_word_store();
        test_byte_store();
        test_half_store();
        test_errors();
        test_reset_store();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem.md
DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words stored (4 KB byte space).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 addr  input  32  byte address, driven by ALU result (out).
REQ-005 wd  input  32  store data (rt register value).
REQ-006 memwrite  input  1  store request for the current cycle.
REQ-007 memop  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved.
REQ-008 load_signed  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-009 pc  input  32  PC of the instruction in flight, used for the store trace only.
REQ-010 rd  output  32  load data, already lane-selected and extended.
REQ-011 addr_err  output  1  access illegal (range, alignment or reserved memop).

Function
REQ-012 Word index SHALL be addr[11:2]; byte lane SHALL be addr[1:0].
REQ-013 addr_err SHALL be combinational and SHALL be 1 when any of the following holds: addr >= 4*DEPTH_WORDS; memop=00 with addr[1:0]!=0; memop=01 with addr[0]!=0; memop=11.
REQ-014 Read SHALL be combinational from the array: word gives mem[index]; half gives mem[index][31:16] if addr[1]=1, else [15:0]; byte gives lane addr[1:0], where lane 0 = bits [7:0].
REQ-015 Sub-word loads SHALL be extended to 32 bits per load_signed.
REQ-016 rd SHALL be 32'h0 whenever addr_err=1.
REQ-017 A store SHALL commit at the rising edge only when memwrite=1, addr_err=0 and reset=0.
REQ-018 A word store SHALL write all 32 bits.
REQ-019 A half store SHALL write wd[15:0] into the addressed half only; the other half is unchanged.
REQ-020 A byte store SHALL write wd[7:0] into the addressed lane only; the other lanes are unchanged.
REQ-021 A store with addr_err=1 SHALL be dropped silently, leaving the array unchanged.
REQ-022 Read during a store to the same address SHALL return the pre-store contents until the edge, and the new contents after the edge (write-first is not permitted).
REQ-023 Each committed store SHALL emit the simulation trace line "@<pc>: *<word-aligned addr> <= <merged 32-bit word>", with all values in 8-digit hex, at the committing edge.
REQ-024 The trace SHALL print the full merged word for sub-word stores, and SHALL print nothing for dropped stores.
REQ-025 memwrite=0 SHALL never alter the array, regardless of the other inputs.

Reset
REQ-026 When reset=1 at a rising edge, every word SHALL be cleared to 32'h0 at that edge.
REQ-027 During reset, any simultaneous store SHALL be ignored and no trace line SHALL be printed.
REQ-028 After reset, rd SHALL read 32'h0 for every legal address.
REQ-029 addr_err remains purely combinational and is unaffected by reset.
REQ-030 Reset asserted between two stores SHALL discard the first store; the second store, after reset deasserts, commits normally.

Verification
REQ-031 Reset, then word store addr=0x10, wd=0x12345678, pc=0x3000 -> next cycle word load of 0x10 gives rd=0x12345678; trace "@00003000: *00000010 <= 12345678".
REQ-032 After REQ-031, byte store addr=0x13, wd=0xAB -> word at 0x10 = 0xAB345678; signed byte load of 0x13 gives 0xFFFFFFAB; unsigned byte load gives 0x000000AB.
REQ-033 Half store addr=0x22, wd=0x8001 into a word holding 0 -> word at 0x20 = 0x80010000; signed half load of 0x22 gives 0xFFFF8001; half load of 0x20 gives 0x00000000.
REQ-034 Misaligned and out-of-range stores (word addr=0x11, half addr=0x21, word addr=0x1000, memop=11) -> addr_err=1, rd=0, array unchanged, no trace.
REQ-035 Word store addr=0x40 with memwrite and reset both high in the same cycle -> word at 0x40 reads 0 after the edge and no trace is printed.
REQ-036 Back-to-back word stores 0x11111111 then 0x22222222 to addr=0x8 -> same-cycle read before the second edge gives 0x11111111; after the edge it gives 0x22222222.
